vbank_array: RTL and testbench



---
 rtl/vbank_array.sv | 151 +++++++++++++++
 tb/tb_vbank_array.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vbank_array.sv
// Banked multi-read-port vector register file with per-bank round-robin arbitration.
// Define VBANK_ARRAY_BYPASS_EN to forward same-cycle write data to reads of the same row.
module vbank_array #(
    parameter int unsigned NUM_BANKS    = 4,
    parameter int unsigned NUM_ROWS     = 32,
    parameter int unsigned NUM_ELEMENTS = 32,
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned NUM_RPORTS   = 2,
    parameter int unsigned INDEX_WIDTH  = $clog2(NUM_BANKS * NUM_ROWS)
) (
    input  logic                                         clk,
    input  logic                                         nRST,
    input  logic [NUM_RPORTS-1:0]                        rreq,
    input  logic [NUM_RPORTS*INDEX_WIDTH-1:0]            raddr,
    output logic [NUM_RPORTS-1:0]                        rready,
    output logic [NUM_RPORTS-1:0]                        rvalid,
    output logic [NUM_RPORTS*NUM_ELEMENTS*DATA_WIDTH-1:0] rdata,
    input  logic                                         wen,
    input  logic [INDEX_WIDTH-1:0]                       waddr,
    input  logic [NUM_ELEMENTS*DATA_WIDTH-1:0]           wdata,
    input  logic [NUM_ELEMENTS-1:0]                      wstrb,
    output logic [15:0]                                  conflict_cnt
);

    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int unsigned BANK_S = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int unsigned ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned PTR_W  = (NUM_RPORTS > 1) ? $clog2(NUM_RPORTS) : 1;
    localparam int unsigned VEC_W  = NUM_ELEMENTS * DATA_WIDTH;
    localparam int unsigned CNT_W  = 16;

    function automatic logic [BANK_W-1:0] addr_bank(input logic [INDEX_WIDTH-1:0] a);
        if (NUM_BANKS > 1) return a[BANK_W-1:0];
        else return '0;
    endfunction

    function automatic logic [ROW_W-1:0] addr_row(input logic [INDEX_WIDTH-1:0] a);
        return ROW_W'(a >> BANK_S);
    endfunction

    logic [VEC_W-1:0]              mem_q [NUM_BANKS][NUM_ROWS];
    logic [PTR_W-1:0]              rr_ptr_q [NUM_BANKS];
    logic [PTR_W-1:0]              rr_ptr_d [NUM_BANKS];
    logic [NUM_RPORTS-1:0]         rvalid_q, rvalid_d;
    logic [NUM_RPORTS*VEC_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;

    logic [BANK_W-1:0]             rbank_c [NUM_RPORTS];
    logic [ROW_W-1:0]              rrow_c  [NUM_RPORTS];
    logic [VEC_W-1:0]              rd_c    [NUM_RPORTS];
    logic [NUM_RPORTS-1:0]         rready_c;
    logic [NUM_BANKS-1:0]          bank_found_c, bank_deny_c;
    logic [PTR_W-1:0]              bank_win_c [NUM_BANKS];
    logic [BANK_W-1:0]             wbank_c;
    logic [ROW_W-1:0]              wrow_c;

    assign wbank_c = addr_bank(waddr);
    assign wrow_c  = addr_row(waddr);

    // Split each read port's global address into bank and row.
    always_comb begin
        for (int p = 0; p < int'(NUM_RPORTS); p++) begin
            rbank_c[p] = addr_bank(raddr[p*INDEX_WIDTH +: INDEX_WIDTH]);
            rrow_c[p]  = addr_row(raddr[p*INDEX_WIDTH +: INDEX_WIDTH]);
        end
    end

    // Per-bank round-robin: first requester at/after the pointer wins, same-row requesters ride along.
    always_comb begin
        int unsigned idx;
        idx          = 0;
        rready_c     = '0;
        bank_found_c = '0;
        bank_deny_c  = '0;
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            bank_win_c[b] = '0;
            rr_ptr_d[b]   = rr_ptr_q[b];
        end
        for (int b = 0; b < int'(NUM_BANKS); b++) begin
            for (int k = 0; k < int'(NUM_RPORTS); k++) begin
                idx = (32'(rr_ptr_q[b]) + 32'(k)) % NUM_RPORTS;
                if (!bank_found_c[b] && rreq[idx] && (rbank_c[idx] == BANK_W'(b))) begin
                    bank_found_c[b] = 1'b1;
                    bank_win_c[b]   = PTR_W'(idx);
                end
            end
            for (int p = 0; p < int'(NUM_RPORTS); p++) begin
                if (rreq[p] && (rbank_c[p] == BANK_W'(b))) begin
                    if (rrow_c[p] == rrow_c[bank_win_c[b]]) rready_c[p] = 1'b1;
                    else bank_deny_c[b] = 1'b1;
                end
            end
            if (bank_deny_c[b]) begin
                rr_ptr_d[b] = PTR_W'((32'(bank_win_c[b]) + 32'd1) % NUM_RPORTS);
            end
        end
    end

    // Read data per port, optionally merged with the same-cycle write.
    always_comb begin
        for (int p = 0; p < int'(NUM_RPORTS); p++) begin
            rd_c[p] = mem_q[rbank_c[p]][rrow_c[p]];
`ifdef VBANK_ARRAY_BYPASS_EN
            if (wen && (waddr == raddr[p*INDEX_WIDTH +: INDEX_WIDTH])) begin
                for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
                    if (wstrb[i]) rd_c[p][i*DATA_WIDTH +: DATA_WIDTH] = wdata[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
`endif
        end
    end

    always_comb begin
        rvalid_d = rreq & rready_c;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        for (int p = 0; p < int'(NUM_RPORTS); p++) begin
            if (rreq[p] && rready_c[p]) rdata_d[p*VEC_W +: VEC_W] = rd_c[p];
        end
        if (|(rreq & ~rready_c) && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
            for (int b = 0; b < int'(NUM_BANKS); b++) rr_ptr_q[b] <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            for (int b = 0; b < int'(NUM_BANKS); b++) rr_ptr_q[b] <= rr_ptr_d[b];
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < int'(NUM_ELEMENTS); i++) begin
                if (wstrb[i]) mem_q[wbank_c][wrow_c][i*DATA_WIDTH +: DATA_WIDTH] <= wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rready       = rready_c;
    assign rvalid       = rvalid_q;
    assign rdata        = rdata_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_vbank_array.sv
// Bench for vbank_array: directed vector table, corner sequences and random traffic vs. a reference model.
module tb_vbank_array;

    localparam int unsigned NB = 4;
    localparam int unsigned NR = 32;
    localparam int unsigned NE = 32;
    localparam int unsigned DW = 16;
    localparam int unsigned NP = 2;
    localparam int unsigned IW = 7;
    localparam int unsigned VW = NE * DW;

    logic               clk = 1'b0;
    logic               nRST;
    logic [NP-1:0]      rreq;
    logic [NP*IW-1:0]   raddr;
    logic [NP-1:0]      rready;
    logic [NP-1:0]      rvalid;
    logic [NP*VW-1:0]   rdata;
    logic               wen;
    logic [IW-1:0]      waddr;
    logic [VW-1:0]      wdata;
    logic [NE-1:0]      wstrb;
    logic [15:0]        conflict_cnt;

    always #5 clk = ~clk;

    vbank_array #(
        .NUM_BANKS(NB), .NUM_ROWS(NR), .NUM_ELEMENTS(NE),
        .DATA_WIDTH(DW), .NUM_RPORTS(NP), .INDEX_WIDTH(IW)
    ) dut (
        .clk(clk), .nRST(nRST), .rreq(rreq), .raddr(raddr), .rready(rready),
        .rvalid(rvalid), .rdata(rdata), .wen(wen), .waddr(waddr), .wdata(wdata),
        .wstrb(wstrb), .conflict_cnt(conflict_cnt)
    );

    // Reference model state
    logic [VW-1:0] m_mem [NB*NR];
    int            m_ptr [NB];
    int            m_cnt;
    logic [NP-1:0] m_gnt;
    logic [NP-1:0] m_rvalid;
    logic [VW-1:0] m_rdata [NP];
    logic [NP-1:0] dut_rdy;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [NP-1:0] rq;
        int            a0;
        int            a1;
        logic [NP-1:0] exp_rdy;
        int            exp_cnt;
    } vec_t;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < int'(NB); b++) m_ptr[b] = 0;
        m_cnt    = 0;
        m_rvalid = '0;
        m_gnt    = '0;
        for (int p = 0; p < int'(NP); p++) m_rdata[p] = '0;
    endtask

    // One clock: drive, check grants, advance the model, check registered outputs.
    task automatic step(input logic [NP-1:0] rq, input int a0, input int a1, input logic we,
                        input int wa, input logic [VW-1:0] wd, input logic [NE-1:0] ws);
        int a[NP];
        int win;
        bit denied;
        logic [VW-1:0] v;
        a[0] = a0;
        a[1] = a1;
        rreq  = rq;
        raddr = {IW'(a1), IW'(a0)};
        wen   = we;
        waddr = IW'(wa);
        wdata = wd;
        wstrb = ws;
        #1;
        m_gnt = '0;
        for (int b = 0; b < int'(NB); b++) begin
            win = -1;
            for (int k = 0; k < int'(NP); k++) begin
                int p;
                p = (m_ptr[b] + k) % NP;
                if (win < 0 && rq[p] && (a[p] % NB) == b) win = p;
            end
            if (win >= 0) begin
                denied = 0;
                for (int p = 0; p < int'(NP); p++) begin
                    if (rq[p] && (a[p] % NB) == b) begin
                        if ((a[p] / NB) == (a[win] / NB)) m_gnt[p] = 1'b1;
                        else denied = 1;
                    end
                end
                if (denied) m_ptr[b] = (win + 1) % NP;
            end
        end
        dut_rdy = rready;
        chk("rready", VW'(rready), VW'(m_gnt));
        if (|(rq & ~m_gnt) && m_cnt < 65535) m_cnt++;
        for (int p = 0; p < int'(NP); p++) begin
            if (m_gnt[p]) begin
                v = m_mem[a[p]];
`ifdef VBANK_ARRAY_BYPASS_EN
                if (we && wa == a[p])
                    for (int i = 0; i < int'(NE); i++) if (ws[i]) v[i*DW +: DW] = wd[i*DW +: DW];
`endif
                m_rdata[p] = v;
            end
        end
        m_rvalid = m_gnt;
        if (we) for (int i = 0; i < int'(NE); i++) if (ws[i]) m_mem[wa][i*DW +: DW] = wd[i*DW +: DW];
        @(posedge clk);
        #1;
        chk("rvalid", VW'(rvalid), VW'(m_rvalid));
        for (int p = 0; p < int'(NP); p++) chk($sformatf("rdata_p%0d", p), rdata[p*VW +: VW], m_rdata[p]);
        chk("conflict_cnt", VW'(conflict_cnt), VW'(m_cnt));
    endtask

    task automatic rd(input logic [NP-1:0] rq, input int a0, input int a1);
        step(rq, a0, a1, 1'b0, 0, '0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        logic [VW-1:0] v;
        logic [NP-1:0] pr;
        int            pa [NP];

        nRST = 1'b0; rreq = '0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) nRST = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_rvalid", VW'(rvalid), '0);
        chk("reset_rdata_p0", rdata[0 +: VW], '0);
        chk("reset_rdata_p1", rdata[VW +: VW], '0);
        chk("reset_cnt", VW'(conflict_cnt), '0);

        // Fill memory: element i of address a = a*256+i, then row 3 of every bank = 16'h1000+i.
        for (int a = 0; a < int'(NB*NR); a++) begin
            for (int i = 0; i < int'(NE); i++) v[i*DW +: DW] = DW'(a * 256 + i);
            step('0, 0, 0, 1'b1, a, v, '1);
        end
        for (int a = 12; a < 16; a++) begin
            for (int i = 0; i < int'(NE); i++) v[i*DW +: DW] = DW'(16'h1000 + i);
            step('0, 0, 0, 1'b1, a, v, '1);
        end

        tbl.push_back('{2'b01, 12, 0, 2'b01, 0});
        tbl.push_back('{2'b11, 4, 8, 2'b01, 1});
        tbl.push_back('{2'b11, 4, 8, 2'b10, 2});
        tbl.push_back('{2'b11, 4, 8, 2'b01, 3});
        tbl.push_back('{2'b11, 5, 5, 2'b11, 3});
        tbl.push_back('{2'b10, 0, 1, 2'b10, 3});
        tbl.push_back('{2'b11, 1, 2, 2'b11, 3});
        tbl.push_back('{2'b11, 0, 4, 2'b10, 4});
        tbl.push_back('{2'b11, 0, 4, 2'b01, 5});
        tbl.push_back('{2'b10, 0, 4, 2'b10, 5});
        for (int t = 0; t < tbl.size(); t++) begin
            rd(tbl[t].rq, tbl[t].a0, tbl[t].a1);
            chk($sformatf("tbl%0d_rready", t), VW'(dut_rdy), VW'(tbl[t].exp_rdy));
            chk($sformatf("tbl%0d_cnt", t), VW'(conflict_cnt), VW'(tbl[t].exp_cnt));
            if (t == 0) begin
                chk("addr12_rvalid0", VW'(rvalid[0]), VW'(1'b1));
                v = rdata[0 +: VW];
                chk("addr12_elem5", VW'(v[5*DW +: DW]), VW'(16'h1005));
            end
            if (t == 4) begin
                v = rdata[VW +: VW];
                chk("bcast_p1_elem3", VW'(v[3*DW +: DW]), VW'(16'h0503));
                chk("bcast_rvalid", VW'(rvalid), VW'(2'b11));
            end
        end

        // Same-cycle write/read of address 7 with only element 0 strobed.
        for (int i = 0; i < int'(NE); i++) v[i*DW +: DW] = 16'hDEAD;
        v[0 +: DW] = 16'hBEEF;
        step(2'b10, 0, 7, 1'b1, 7, v, 32'h0000_0001);
        v = rdata[VW +: VW];
`ifdef VBANK_ARRAY_BYPASS_EN
        chk("rw_same_elem0", VW'(v[0 +: DW]), VW'(16'hBEEF));
`else
        chk("rw_same_elem0", VW'(v[0 +: DW]), VW'(16'h0700));
`endif
        chk("rw_same_elem1", VW'(v[1*DW +: DW]), VW'(16'h0701));
        rd(2'b10, 0, 7);
        v = rdata[VW +: VW];
        chk("reread_elem0", VW'(v[0 +: DW]), VW'(16'hBEEF));
        chk("reread_elem1", VW'(v[1*DW +: DW]), VW'(16'h0701));

        // Random traffic; a denied request is held until granted.
        pr = '0;
        for (int p = 0; p < int'(NP); p++) pa[p] = 0;
        for (int n = 0; n < 2000; n++) begin
            logic [VW-1:0] wd;
            for (int p = 0; p < int'(NP); p++) begin
                if (!pr[p] || m_gnt[p]) begin
                    pr[p] = ($urandom_range(0, 3) != 0);
                    pa[p] = $urandom_range(0, 15);
                end
            end
            for (int i = 0; i < int'(NE); i++) wd[i*DW +: DW] = DW'($urandom);
            step(pr, pa[0], pa[1], 1'($urandom_range(0, 1)), $urandom_range(0, 15), wd, NE'($urandom));
        end

        // Saturation of the conflict counter.
        rd(2'b11, 4, 8);
        repeat (70000) @(posedge clk);
        #1;
        chk("cnt_saturated", VW'(conflict_cnt), VW'(16'hFFFF));
        repeat (3) @(posedge clk);
        #1;
        chk("cnt_saturated_stable", VW'(conflict_cnt), VW'(16'hFFFF));

        // Reset while requests are being granted.
        #2 nRST = 1'b0;
        #1;
        chk("midreset_rvalid", VW'(rvalid), '0);
        chk("midreset_rdata_p0", rdata[0 +: VW], '0);
        chk("midreset_rdata_p1", rdata[VW +: VW], '0);
        chk("midreset_cnt", VW'(conflict_cnt), '0);
        rreq = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk("inreset_rvalid", VW'(rvalid), '0);
        @(negedge clk) nRST = 1'b1;
        @(posedge clk);
        #1;
        rd(2'b11, 4, 8);
        chk("post_reset_first_gnt", VW'(dut_rdy), VW'(2'b01));
        rd(2'b11, 4, 8);
        chk("post_reset_second_gnt", VW'(dut_rdy), VW'(2'b10));
        chk("post_reset_cnt", VW'(conflict_cnt), VW'(16'd2));
        rd(2'b00, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
